// File: rtl/bloom_lut_loader_pkg.sv
// bloom_lut_loader_pkg: shared constants and FSM state type for the bloom filter LUT loader
package bloom_lut_loader_pkg;
  localparam int CSR_DATA_W = 16;
  localparam int CSR_ADDR_W = 12;
  localparam int LUT_DATA_W = 8;
  localparam int LUT_ADDR_W = 18;
  localparam int POLL_MAX_DEF = 256;
  localparam int EN = 0;
  localparam int HASH_LUT_CLEAN = 1;
  typedef enum logic [2:0] {
    IDLE, DIS, CLR, POLL_RD, POLL_WT, LOAD, ENA, ERR
  } lut_loader_state_t;
endpackage

// File: rtl/bloom_lut_loader.sv
// bloom_lut_loader: disables the filter, cleans the hash LUT, loads streamed entries, re-enables
module bloom_lut_loader
  import bloom_lut_loader_pkg::*;
#(
  parameter int AMM_CSR_DATA_W = CSR_DATA_W,
  parameter int AMM_CSR_ADDR_W = CSR_ADDR_W,
  parameter int AMM_LUT_DATA_W = LUT_DATA_W,
  parameter int AMM_LUT_ADDR_W = LUT_ADDR_W,
  parameter int POLL_MAX = POLL_MAX_DEF
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic                      start_i,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      err_o,
  input  logic [AMM_LUT_ADDR_W-1:0] entry_addr_i,
  input  logic                      entry_valid_i,
  output logic                      entry_ready_o,
  input  logic                      entry_last_i,
  output logic [AMM_CSR_ADDR_W-1:0] csr_address_o,
  output logic                      csr_write_o,
  output logic [AMM_CSR_DATA_W-1:0] csr_writedata_o,
  output logic                      csr_read_o,
  input  logic [AMM_CSR_DATA_W-1:0] csr_readdata_i,
  input  logic                      csr_readdatavalid_i,
  input  logic                      csr_waitrequest_i,
  output logic [AMM_LUT_ADDR_W-1:0] lut_address_o,
  output logic                      lut_write_o,
  output logic [AMM_LUT_DATA_W-1:0] lut_writedata_o,
  input  logic                      lut_waitrequest_i
);
  localparam int CNT_W = $clog2(POLL_MAX + 1);
  lut_loader_state_t state, next;
  logic [CNT_W-1:0] cnt;
  logic last_seen;
  logic csr_acc, lut_acc, entry_acc, start_acc;
  logic busy_d, done_d, err_d, csr_write_d, csr_read_d;
  logic [AMM_CSR_ADDR_W-1:0] csr_address_d;
  logic [AMM_CSR_DATA_W-1:0] csr_writedata_d;
  logic unused;
  assign unused = ^csr_readdata_i[AMM_CSR_DATA_W-1:1];
  assign csr_acc = (csr_write_o | csr_read_o) & ~csr_waitrequest_i;
  assign lut_acc = lut_write_o & ~lut_waitrequest_i;
  assign start_acc = (state == IDLE) & start_i;
  assign entry_ready_o = (state == LOAD) & ~last_seen & (~lut_write_o | ~lut_waitrequest_i);
  assign entry_acc = entry_valid_i & entry_ready_o;
  // state register
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) state <= IDLE;
    else state <= next;
  // next-state logic; LOAD exits only once the final entry's write has been accepted
  always_comb begin
    next = state;
    case (state)
      IDLE:    if (start_i) next = DIS;
      DIS:     if (csr_acc) next = CLR;
      CLR:     if (csr_acc) next = POLL_RD;
      POLL_RD: if (csr_acc) next = POLL_WT;
      POLL_WT: if (csr_readdatavalid_i)
                 next = !csr_readdata_i[0] ? LOAD : (cnt < CNT_W'(POLL_MAX)) ? POLL_RD : ERR;
      LOAD:    if (last_seen & (~lut_write_o | lut_acc)) next = ENA;
      ENA:     if (csr_acc) next = IDLE;
      default: next = IDLE;
    endcase
  end
  // output decode from the upcoming state so every output leaves a flop
  always_comb begin
    csr_write_d = next inside {DIS, CLR, ENA};
    csr_read_d = next == POLL_RD;
    csr_address_d = next inside {CLR, POLL_RD} ? AMM_CSR_ADDR_W'(HASH_LUT_CLEAN) : AMM_CSR_ADDR_W'(EN);
    csr_writedata_d = AMM_CSR_DATA_W'(next inside {CLR, ENA});
    busy_d = !(next inside {IDLE, ERR});
    done_d = (next == ERR) | ((state == ENA) & (next == IDLE));
    err_d = (next == ERR) | (err_o & ~start_acc);
  end
  // registered status and CSR command outputs
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      busy_o <= 1'b0;
      done_o <= 1'b0;
      err_o <= 1'b0;
      csr_write_o <= 1'b0;
      csr_read_o <= 1'b0;
      csr_address_o <= '0;
      csr_writedata_o <= '0;
    end else begin
      busy_o <= busy_d;
      done_o <= done_d;
      err_o <= err_d;
      csr_write_o <= csr_write_d;
      csr_read_o <= csr_read_d;
      csr_address_o <= csr_address_d;
      csr_writedata_o <= csr_writedata_d;
    end
  // completed clean-status reads since the accepted start
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) cnt <= '0;
    else if (start_acc) cnt <= '0;
    else if ((state == POLL_RD) & csr_acc) cnt <= cnt + 1'b1;
  // remembers that the final entry was taken so the stream is not drained further
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) last_seen <= 1'b0;
    else if (state != LOAD) last_seen <= 1'b0;
    else if (entry_acc & entry_last_i) last_seen <= 1'b1;
  // LUT write pipeline: one stage between the entry stream and the LUT port
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      lut_address_o <= '0;
      lut_write_o <= 1'b0;
      lut_writedata_o <= '0;
    end else if (entry_acc) begin
      lut_address_o <= entry_addr_i;
      lut_write_o <= 1'b1;
      lut_writedata_o <= AMM_LUT_DATA_W'(1);
    end else if (lut_acc) lut_write_o <= 1'b0;
endmodule

// File: tb/tb_bloom_lut_loader.sv
// tb_bloom_lut_loader: table-driven runs with slave models and expected-write scoreboards
module tb_bloom_lut_loader;
  logic clk = 0, rst_n_i = 0, start_i = 0;
  logic busy_o, done_o, err_o, entry_ready_o, csr_write_o, csr_read_o, lut_write_o;
  logic [17:0] entry_addr_i = 0, lut_address_o;
  logic entry_valid_i = 0, entry_last_i = 0;
  logic [11:0] csr_address_o;
  logic [15:0] csr_writedata_o, csr_readdata_i = 0;
  logic csr_readdatavalid_i = 0, csr_waitrequest_i = 0, lut_waitrequest_i = 0;
  logic [7:0] lut_writedata_o;
  logic [63:0] outs;
  typedef struct {int n; int busy; bit waits; bit gaps; bit err; int reads; bit tim;} vec_t;
  vec_t vecs[7];
  logic [17:0] fixed_addr [3] = '{18'h00005, 18'h02001, 18'h3FFFF};
  logic [27:0] exp_csr[$];
  logic [17:0] exp_lut[$];
  logic [18:0] src_q[$];
  int n_cmp = 0, n_bad = 0;
  int cyc = 0, t0, t_wr1, t_rd1, t_lut1, t_en, t_done, n_reads, n_rdv, busy_left = 0, exp_reads = 0;
  bit waits = 0, gaps = 0, rd_pend = 0, ent_taken = 0, hold_csr = 0, hold_lut = 0;
  logic [29:0] csr_snap;
  logic [26:0] lut_snap;

  bloom_lut_loader #(.POLL_MAX(4)) dut (
    .clk_i(clk), .rst_n_i(rst_n_i), .start_i(start_i), .busy_o(busy_o), .done_o(done_o),
    .err_o(err_o), .entry_addr_i(entry_addr_i), .entry_valid_i(entry_valid_i),
    .entry_ready_o(entry_ready_o), .entry_last_i(entry_last_i), .csr_address_o(csr_address_o),
    .csr_write_o(csr_write_o), .csr_writedata_o(csr_writedata_o), .csr_read_o(csr_read_o),
    .csr_readdata_i(csr_readdata_i), .csr_readdatavalid_i(csr_readdatavalid_i),
    .csr_waitrequest_i(csr_waitrequest_i), .lut_address_o(lut_address_o),
    .lut_write_o(lut_write_o), .lut_writedata_o(lut_writedata_o),
    .lut_waitrequest_i(lut_waitrequest_i));

  always #5 clk = ~clk;
  assign outs = {3'b0, busy_o, done_o, err_o, entry_ready_o, csr_write_o, csr_read_o,
                 csr_address_o, csr_writedata_o, lut_address_o, lut_write_o, lut_writedata_o};

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // slave models, entry source and bus monitor; inputs change on negedge, handshakes read 1ns later
  always @(negedge clk) begin
    if (!rst_n_i) begin
      csr_readdatavalid_i = 0; csr_readdata_i = 0; csr_waitrequest_i = 0; lut_waitrequest_i = 0;
      entry_valid_i = 0; ent_taken = 0; rd_pend = 0; hold_csr = 0; hold_lut = 0;
    end else begin
      csr_readdatavalid_i = rd_pend;
      csr_readdata_i = {15'b0, rd_pend && busy_left > 0};
      if (rd_pend) begin
        n_rdv++;
        if (busy_left > 0) busy_left--;
      end
      rd_pend = 0;
      csr_waitrequest_i = waits && ($urandom_range(0, 1) == 1);
      lut_waitrequest_i = waits && ($urandom_range(0, 1) == 1);
      if (ent_taken) begin
        entry_valid_i = 0;
        ent_taken = 0;
      end
      if (!entry_valid_i && src_q.size() > 0 && (!gaps || $urandom_range(0, 2) != 0)) begin
        {entry_last_i, entry_addr_i} = src_q.pop_front();
        entry_valid_i = 1;
      end
      #1;
      cyc++;
      if (start_i && !busy_o && t0 < 0) t0 = cyc;
      if (hold_csr) check("csr_hold", {csr_address_o, csr_writedata_o, csr_write_o, csr_read_o}, csr_snap);
      if (hold_lut) check("lut_hold", {lut_address_o, lut_writedata_o, lut_write_o}, lut_snap);
      hold_csr = (csr_write_o || csr_read_o) && csr_waitrequest_i;
      csr_snap = {csr_address_o, csr_writedata_o, csr_write_o, csr_read_o};
      hold_lut = lut_write_o && lut_waitrequest_i;
      lut_snap = {lut_address_o, lut_writedata_o, lut_write_o};
      if (csr_write_o && csr_read_o) check("csr_rd_wr_both", {csr_write_o, csr_read_o}, 0);
      if (csr_write_o && !csr_waitrequest_i) begin
        if (t_wr1 < 0) t_wr1 = cyc;
        if (csr_address_o == 0 && csr_writedata_o == 1) t_en = cyc;
        if (exp_csr.size() == 0) check("csr_wr_extra", {1'b1, csr_address_o, csr_writedata_o}, 0);
        else check("csr_wr", {csr_address_o, csr_writedata_o}, exp_csr.pop_front());
      end
      if (csr_read_o && !csr_waitrequest_i) begin
        if (t_rd1 < 0) t_rd1 = cyc;
        n_reads++;
        rd_pend = 1;
      end
      if (entry_valid_i && entry_ready_o) ent_taken = 1;
      if (lut_write_o && !lut_waitrequest_i) begin
        if (t_lut1 < 0) begin
          t_lut1 = cyc;
          check("lut_after_polls", n_rdv, exp_reads);
        end
        if (exp_lut.size() == 0) check("lut_wr_extra", {1'b1, lut_address_o}, 0);
        else check("lut_wr", {lut_address_o, lut_writedata_o}, {exp_lut.pop_front(), 8'h01});
      end
      if (done_o) t_done = cyc;
    end
  end

  task automatic clear_marks();
    t0 = -1; t_wr1 = -1; t_rd1 = -1; t_lut1 = -1; t_en = -1; t_done = -1;
    n_reads = 0; n_rdv = 0;
  endtask

  task automatic run(input vec_t v, input bit poke);
    logic [17:0] a;
    bit poked = 0;
    waits = v.waits; gaps = v.gaps; busy_left = v.busy; exp_reads = v.reads;
    clear_marks();
    exp_csr.push_back({12'd0, 16'd0});
    exp_csr.push_back({12'd1, 16'd1});
    if (!v.err) exp_csr.push_back({12'd0, 16'd1});
    for (int i = 0; i < v.n; i++) begin
      a = v.tim ? fixed_addr[i] : 18'($urandom);
      src_q.push_back({i == v.n - 1, a});
      if (!v.err) exp_lut.push_back(a);
    end
    @(negedge clk); start_i = 1;
    @(negedge clk); start_i = 0; #2;
    check("busy_c1", busy_o, 1);
    check("err_clr_c1", err_o, 0);
    check("csr_wr_c1", csr_write_o, 1);
    for (int i = 0; i < 3000 && t_done < 0; i++) begin
      @(negedge clk); #2;
      start_i = poke && !poked && lut_write_o;
      if (start_i) poked = 1;
    end
    start_i = 0;
    check("done_seen", t_done >= 0, 1);
    check("err_o", err_o, v.err);
    check("n_reads", n_reads, v.reads);
    if (!v.err) check("done_after_en", t_done - t_en, 1);
    if (v.err && !v.gaps) check("err_no_consume", src_q.size(), v.n - 1);
    if (v.tim) begin
      check("t_first_csr_wr", t_wr1 - t0, 1);
      check("t_first_read", t_rd1 - t0, 3);
      check("t_first_lut_wr", t_lut1 - t0, 6);
    end
    check("csr_q_empty", exp_csr.size(), 0);
    check("lut_q_empty", exp_lut.size(), 0);
    @(negedge clk); #2;
    check("done_pulse", done_o, 0);
    check("busy_end", busy_o, 0);
    if (poke) begin
      repeat (3) @(negedge clk);
      #2 check("start_not_queued", busy_o, 0);
    end
    src_q.delete();
    entry_valid_i = 0;
  endtask

  initial begin
    vecs[0] = '{3, 0, 0, 0, 0, 1, 1};
    vecs[1] = '{4, 3, 0, 0, 0, 4, 0};
    vecs[2] = '{2, 99, 0, 0, 1, 4, 0};
    vecs[3] = '{8, 1, 1, 1, 0, 2, 0};
    vecs[4] = '{5, 2, 1, 1, 0, 3, 0};
    vecs[5] = '{6, 99, 1, 1, 1, 4, 0};
    vecs[6] = '{1, 0, 1, 0, 0, 1, 0};
    clear_marks();
    repeat (3) @(negedge clk);
    #1 check("reset_outs", outs, 0);
    rst_n_i = 1;
    for (int k = 0; k < 7; k++) run(vecs[k], 0);
    run('{10, 0, 0, 1, 0, 1, 0}, 1);
    waits = 0; gaps = 0; busy_left = 0; exp_reads = 1;
    clear_marks();
    exp_csr.push_back({12'd0, 16'd0});
    exp_csr.push_back({12'd1, 16'd1});
    for (int i = 0; i < 6; i++) begin
      src_q.push_back({i == 5, 18'(i * 3 + 7)});
      exp_lut.push_back(18'(i * 3 + 7));
    end
    @(negedge clk); start_i = 1;
    @(negedge clk); start_i = 0;
    for (int i = 0; i < 50 && !lut_write_o; i++) begin
      @(negedge clk); #2;
    end
    check("reached_load", lut_write_o, 1);
    rst_n_i = 0;
    #1 check("async_rst_outs", outs, 0);
    exp_csr.delete(); exp_lut.delete(); src_q.delete();
    repeat (2) @(negedge clk);
    rst_n_i = 1;
    run(vecs[0], 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
